// File: rtl/bus_arb4_pkg.sv
// Shared constants for the four-requester bus arbiter: FSM encoding,
// requester count, select width and the pointer reset value.
package bus_arb4_pkg;

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  localparam int SEL_W   = 2;
  localparam int NUM_REQ = 4;

  localparam logic [SEL_W-1:0] PTR_RST = 2'd3;

endpackage

// File: rtl/bus_arb4_rr_pick4.sv
// Combinational round-robin picker: scans ptr+1, ptr+2, ptr+3, ptr (mod 4)
// and returns the first active requester as one-hot and as an index.
module rr_pick4
  import bus_arb4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [SEL_W-1:0]   idx,
  output logic               any_req
);

  logic             found;
  logic [SEL_W-1:0] cand;

  always_comb begin
    idx   = ptr;
    found = 1'b0;
    cand  = '0;
    // Offset 4 wraps to ptr itself, so the last-served requester comes last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

  assign any_req = |req;
  assign pick    = any_req ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/bus_arb4.sv
// Round-robin arbiter for the shared memory port: grants one of four
// requesters, runs the memory handshake and returns data plus a done pulse.
// Optional mem_ready timeout is built when BUS_ARB4_TIMEOUT_EN is defined.
module bus_arb4
  import bus_arb4_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [SEL_W-1:0]          sel,
  output logic                      busy,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_valid,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ready,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      timeout_err
);

  // Memory handshake: mem_valid rises with the grant and stays high, with
  // sel/mem_we/mem_wdata stable, until the first cycle mem_ready is sampled
  // high; that cycle completes the transfer and mem_valid drops next edge.

  logic                state, state_d;
  logic [SEL_W-1:0]    ptr, ptr_d;
  logic [NUM_REQ-1:0]  pick;
  logic [SEL_W-1:0]    pick_idx;
  logic                any_req;
  logic                start, finish, tmo;

  logic [NUM_REQ-1:0]  gnt_d, done_d;
  logic [SEL_W-1:0]    sel_d;
  logic                busy_d, mem_valid_d;
  logic [DATA_W-1:0]   rdata_d;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr),
    .pick    (pick),
    .idx     (pick_idx),
    .any_req (any_req)
  );

`ifdef BUS_ARB4_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  // Abort in the cycle the count would reach TIMEOUT; mem_ready has priority.
  assign tmo = (state == BUSY) && !mem_ready && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo;
      if (state == IDLE)
        cnt <= '0;
      else if (!mem_ready)
        cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign tmo         = 1'b0;
  // Constant 0: TIMEOUT only has meaning when the counter is built.
  assign timeout_err = (TIMEOUT < 0);
`endif

  assign start  = (state == IDLE) && any_req;
  assign finish = (state == BUSY) && (mem_ready || tmo);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= PTR_RST;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    if (start)
      state_d = BUSY;
    if (finish) begin
      state_d = IDLE;
      ptr_d   = sel;
    end
  end

  always_comb begin
    gnt_d       = gnt;
    sel_d       = sel;
    busy_d      = busy;
    mem_valid_d = mem_valid;
    done_d      = '0;
    rdata_d     = rdata;
    if (state == IDLE) begin
      gnt_d       = '0;
      sel_d       = '0;
      busy_d      = 1'b0;
      mem_valid_d = 1'b0;
      if (start) begin
        gnt_d       = pick;
        sel_d       = pick_idx;
        busy_d      = 1'b1;
        mem_valid_d = 1'b1;
      end
    end else if (finish) begin
      gnt_d       = '0;
      sel_d       = '0;
      busy_d      = 1'b0;
      mem_valid_d = 1'b0;
      done_d      = NUM_REQ'(1) << sel;
      if (mem_ready)
        rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt       <= '0;
      sel       <= '0;
      busy      <= 1'b0;
      mem_valid <= 1'b0;
      done      <= '0;
      rdata     <= '0;
    end else begin
      gnt       <= gnt_d;
      sel       <= sel_d;
      busy      <= busy_d;
      mem_valid <= mem_valid_d;
      done      <= done_d;
      rdata     <= rdata_d;
    end
  end

  // 4:1 write-data mux steered by the registered select.
  always_comb begin
    case (sel)
      2'd0:    mem_wdata = req_wdata[0*DATA_W +: DATA_W];
      2'd1:    mem_wdata = req_wdata[1*DATA_W +: DATA_W];
      2'd2:    mem_wdata = req_wdata[2*DATA_W +: DATA_W];
      default: mem_wdata = req_wdata[3*DATA_W +: DATA_W];
    endcase
  end

  assign mem_we = mem_valid & req_we[sel];

endmodule
